dmem_responder: RTL and testbench

// Memory-side responder for the core's data-memory port: accepts load/store requests issued by the MEM stage,

---
 rtl/dmem_responder_pkg.sv | 62 ++++++
 rtl/dmem_responder_bram.sv | 27 ++
 rtl/dmem_responder.sv | 113 +++++++++++
 tb/tb_dmem_responder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types, funct3 encodings and lane/extension helpers for the data-memory responder.
package dmem_responder_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;
  typedef logic [2:0]      funct3_t;

  typedef enum logic {LITTLE_ENDIAN, BIG_ENDIAN} ENDIANESS_t;
  typedef enum logic [1:0] {IDLE, READ, RESP} dmem_state_t;

  localparam funct3_t LB  = 3'b000;
  localparam funct3_t LH  = 3'b001;
  localparam funct3_t LW  = 3'b010;
  localparam funct3_t LBU = 3'b100;
  localparam funct3_t LHU = 3'b101;
  localparam funct3_t SB  = 3'b000;
  localparam funct3_t SH  = 3'b001;
  localparam funct3_t SW  = 3'b010;

  localparam logic [3:0] B_EN_BASE = 4'b0001;
  localparam logic [3:0] H_EN_BASE = 4'b0011;
  localparam logic [3:0] W_EN_BASE = 4'b1111;

  // Access size in bytes from funct3[1:0]; 0 marks the unused encoding.
  function automatic logic [2:0] access_size(funct3_t f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] size_en(logic [2:0] size);
    case (size)
      3'd1:    return B_EN_BASE;
      3'd2:    return H_EN_BASE;
      3'd4:    return W_EN_BASE;
      default: return 4'b0000;
    endcase
  endfunction

  // BIG lsb is 32-8*(o+s); computed mod 32, so o+s==4 folds to lane 0.
  function automatic logic [4:0] lane_lsb(ENDIANESS_t endian, logic [1:0] offset, logic [2:0] size);
    logic [1:0] t;
    t = offset + size[1:0];
    if (endian == LITTLE_ENDIAN) return {offset, 3'b000};
    else                         return 5'd0 - {t, 3'b000};
  endfunction

  function automatic data_t ld_extend(data_t field, funct3_t f3);
    case (f3)
      LB:      return {{(XLEN-8){field[7]}}, field[7:0]};
      LH:      return {{(XLEN-16){field[15]}}, field[15:0]};
      LBU:     return {{(XLEN-8){1'b0}}, field[7:0]};
      LHU:     return {{(XLEN-16){1'b0}}, field[15:0]};
      default: return field;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_bram.sv
// Single-port data RAM: synchronous read, per-byte write enables.
module dmem_bram
  import dmem_responder_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     i_en,
  input  logic [3:0]               i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [XLEN-1:0]          i_wdata,
  output logic [XLEN-1:0]          o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: decodes MEM-stage load/store requests, steers byte lanes and
// returns extended load data over a single-outstanding valid/ready response channel.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int         DEPTH     = 1024,
  parameter ENDIANESS_t ENDIAN    = BIG_ENDIAN,
  parameter string      INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t r_state, w_nextState;

  logic [2:0] r_funct3;
  logic [1:0] r_offset;
  logic       r_err;
  data_t      r_rspRdata;

  logic       w_accept, w_misalign, w_badFunct3, w_outOfRange, w_err;
  logic [1:0] w_offset;
  logic [2:0] w_size;
  logic [4:0] w_lsb, w_rdLsb;
  logic [3:0] w_byteEn, w_ramWe;
  logic       w_ramEn;
  data_t      w_ramWdata, w_ramRdata;

  assign w_offset = req_addr[1:0];
  assign w_size   = access_size(req_funct3);
  assign w_lsb    = lane_lsb(ENDIAN, w_offset, w_size);
  assign w_rdLsb  = lane_lsb(ENDIAN, r_offset, access_size(r_funct3));

  assign w_misalign   = ((w_size == 3'd2) && w_offset[0]) || ((w_size == 3'd4) && (w_offset != 2'b00));
  assign w_badFunct3  = req_we ? (req_funct3 >= 3'b011) : (req_funct3 inside {3'b011, 3'b110, 3'b111});
  // DEPTH is a power of two, so any set bit above the word index is out of range.
  assign w_outOfRange = (req_addr[XLEN-1:AW+2] != '0);
  assign w_err        = w_misalign || w_badFunct3 || w_outOfRange;

  assign w_accept   = rst_n && req_valid && req_ready;
  assign w_byteEn   = size_en(w_size) << w_lsb[4:3];
  assign w_ramWdata = req_wdata << w_lsb;
  assign w_ramEn    = w_accept && !w_err;
  assign w_ramWe    = req_we ? w_byteEn : 4'b0000;

  dmem_bram #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_bram (
    .clk    (clk),
    .i_en   (w_ramEn),
    .i_we   (w_ramWe),
    .i_addr (req_addr[AW+1:2]),
    .i_wdata(w_ramWdata),
    .o_rdata(w_ramRdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (w_accept) w_nextState = (req_we || w_err) ? RESP : READ;
      end
      READ: w_nextState = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Response data is cleared at acceptance so stores and errors return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_funct3   <= '0;
      r_offset   <= '0;
      r_err      <= 1'b0;
      r_rspRdata <= '0;
    end else if (w_accept) begin
      r_funct3   <= req_funct3;
      r_offset   <= w_offset;
      r_err      <= w_err;
      r_rspRdata <= '0;
    end else if (r_state == READ) begin
      r_rspRdata <= ld_extend(w_ramRdata >> w_rdLsb, r_funct3);
    end
  end

  assign rsp_rdata = r_rspRdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a BIG and a LITTLE instance share one request stream.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic [31:0] expRdLe;
    logic        chkLe;
    logic        expErr;
    logic [3:0]  expLat;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] rdataLe;
    logic        chkLe;
    logic        err;
    logic [3:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        reqReadyLe, rspValidLe, rspErrLe;
  logic [31:0] rspRdataLe;

  exp_t        sb[$];
  int          assertCount = 0;
  int          failCount = 0;
  logic [7:0]  modelMem [32];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .ENDIAN(BIG_ENDIAN), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH(1024), .ENDIAN(LITTLE_ENDIAN), .INIT_FILE("")) dutLe (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(reqReadyLe), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspValidLe),
    .rsp_ready(rsp_ready), .rsp_rdata(rspRdataLe), .rsp_err(rspErrLe)
  );

  // Issues one request, waits for its response and returns what was observed.
  task automatic sendReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rd, output logic [31:0] rdLe,
                         output logic er, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      assertCount++; failCount++;
      $display("[TB] FAIL req_ready wait: got 0, expected 1 within 20 cycles");
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    rd = rsp_rdata; rdLe = rspRdataLe; er = rsp_err;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    assertCount++; if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset rsp_valid: got %b, expected 0", rsp_valid); end
    assertCount++; if (rsp_rdata !== 32'h0) begin failCount++; $display("[TB] FAIL reset rsp_rdata: got %h, expected 0", rsp_rdata); end
    assertCount++; if (rsp_err !== 1'b0) begin failCount++; $display("[TB] FAIL reset rsp_err: got %b, expected 0", rsp_err); end
    assertCount++; if (rspValidLe !== 1'b0) begin failCount++; $display("[TB] FAIL reset le rsp_valid: got %b, expected 0", rspValidLe); end
    rst_n = 1'b1;
    @(negedge clk);
    assertCount++; if (req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset req_ready: got %b, expected 1", req_ready); end
    assertCount++; if (reqReadyLe !== 1'b1 || rspErrLe !== 1'b0) begin failCount++; $display("[TB] FAIL reset le ready/err: got %b/%b, expected 1/0", reqReadyLe, rspErrLe); end
  endtask

  task automatic test_word;
    req_t t[2];
    logic [31:0] rd, rdLe; logic er; int lat; exp_t e;
    t = '{'{1'b1, SW, 32'h010, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1},
          '{1'b0, LW, 32'h010, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 4'd2}};
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{t[i].expRd, t[i].expRdLe, t[i].chkLe, t[i].expErr, t[i].expLat});
      sendReq(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata) begin failCount++; $display("[TB] FAIL word[%0d] rdata: got %h, expected %h", i, rd, e.rdata); end
      assertCount++; if (er !== e.err) begin failCount++; $display("[TB] FAIL word[%0d] err: got %b, expected %b", i, er, e.err); end
      assertCount++; if (lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL word[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
      if (e.chkLe) begin
        assertCount++; if (rdLe !== e.rdataLe) begin failCount++; $display("[TB] FAIL word[%0d] le rdata: got %h, expected %h", i, rdLe, e.rdataLe); end
      end
    end
  endtask

  task automatic test_byte;
    req_t t[4];
    logic [31:0] rd, rdLe; logic er; int lat; exp_t e;
    t = '{'{1'b0, LB,  32'h011, 32'h0, 32'hFFFFFFAD, 32'hFFFFFFBE, 1'b1, 1'b0, 4'd2},
          '{1'b0, LBU, 32'h011, 32'h0, 32'h000000AD, 32'h000000BE, 1'b1, 1'b0, 4'd2},
          '{1'b0, LB,  32'h010, 32'h0, 32'hFFFFFFDE, 32'hFFFFFFEF, 1'b1, 1'b0, 4'd2},
          '{1'b0, LBU, 32'h013, 32'h0, 32'h000000EF, 32'h000000DE, 1'b1, 1'b0, 4'd2}};
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{t[i].expRd, t[i].expRdLe, t[i].chkLe, t[i].expErr, t[i].expLat});
      sendReq(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata) begin failCount++; $display("[TB] FAIL byte[%0d] rdata: got %h, expected %h", i, rd, e.rdata); end
      assertCount++; if (er !== e.err) begin failCount++; $display("[TB] FAIL byte[%0d] err: got %b, expected %b", i, er, e.err); end
      assertCount++; if (lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL byte[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
      if (e.chkLe) begin
        assertCount++; if (rdLe !== e.rdataLe) begin failCount++; $display("[TB] FAIL byte[%0d] le rdata: got %h, expected %h", i, rdLe, e.rdataLe); end
      end
    end
  endtask

  task automatic test_half;
    req_t t[6];
    logic [31:0] rd, rdLe; logic er; int lat; exp_t e;
    t = '{'{1'b1, SH,  32'h012, 32'h00001234, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1},
          '{1'b0, LW,  32'h010, 32'h0, 32'hDEAD1234, 32'h1234BEEF, 1'b1, 1'b0, 4'd2},
          '{1'b0, LH,  32'h012, 32'h0, 32'h00001234, 32'h00001234, 1'b1, 1'b0, 4'd2},
          '{1'b0, LH,  32'h010, 32'h0, 32'hFFFFDEAD, 32'hFFFFBEEF, 1'b1, 1'b0, 4'd2},
          '{1'b0, LHU, 32'h010, 32'h0, 32'h0000DEAD, 32'h0000BEEF, 1'b1, 1'b0, 4'd2},
          '{1'b0, LB,  32'h012, 32'h0, 32'h00000012, 32'h00000034, 1'b1, 1'b0, 4'd2}};
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{t[i].expRd, t[i].expRdLe, t[i].chkLe, t[i].expErr, t[i].expLat});
      sendReq(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata) begin failCount++; $display("[TB] FAIL half[%0d] rdata: got %h, expected %h", i, rd, e.rdata); end
      assertCount++; if (er !== e.err) begin failCount++; $display("[TB] FAIL half[%0d] err: got %b, expected %b", i, er, e.err); end
      assertCount++; if (lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL half[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
      if (e.chkLe) begin
        assertCount++; if (rdLe !== e.rdataLe) begin failCount++; $display("[TB] FAIL half[%0d] le rdata: got %h, expected %h", i, rdLe, e.rdataLe); end
      end
    end
  endtask

  task automatic test_errors;
    req_t t[14];
    logic [31:0] rd, rdLe; logic er; int lat; exp_t e;
    t = '{'{1'b1, SW,     32'h000,  32'h11223344, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1},
          '{1'b0, LW,     32'h013,  32'h0,        32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b0, LH,     32'h011,  32'h0,        32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b0, 3'b011, 32'h000,  32'h0,        32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b0, 3'b110, 32'h000,  32'h0,        32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b1, 3'b011, 32'h000,  32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b1, 3'b100, 32'h000,  32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b1, SH,     32'h011,  32'h0000FFFF, 32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b1, SW,     32'h1000, 32'hCAFEF00D, 32'h0, 32'h0, 1'b1, 1'b1, 4'd1},
          '{1'b0, LW,     32'h000,  32'h0, 32'h11223344, 32'h11223344, 1'b1, 1'b0, 4'd2},
          '{1'b0, LW,     32'h010,  32'h0, 32'hDEAD1234, 32'h1234BEEF, 1'b1, 1'b0, 4'd2},
          '{1'b1, SW,     32'hFFC,  32'h55AA55AA, 32'h0, 32'h0, 1'b1, 1'b0, 4'd1},
          '{1'b0, LW,     32'hFFC,  32'h0, 32'h55AA55AA, 32'h55AA55AA, 1'b1, 1'b0, 4'd2},
          '{1'b0, LW,     32'h1000, 32'h0,        32'h0, 32'h0, 1'b1, 1'b1, 4'd1}};
    for (int i = 0; i < 14; i++) begin
      sb.push_back('{t[i].expRd, t[i].expRdLe, t[i].chkLe, t[i].expErr, t[i].expLat});
      sendReq(t[i].we, t[i].f3, t[i].addr, t[i].wdata, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata) begin failCount++; $display("[TB] FAIL err[%0d] rdata: got %h, expected %h", i, rd, e.rdata); end
      assertCount++; if (er !== e.err) begin failCount++; $display("[TB] FAIL err[%0d] err: got %b, expected %b", i, er, e.err); end
      assertCount++; if (lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL err[%0d] latency: got %0d, expected %0d", i, lat, e.lat); end
      if (e.chkLe) begin
        assertCount++; if (rdLe !== e.rdataLe) begin failCount++; $display("[TB] FAIL err[%0d] le rdata: got %h, expected %h", i, rdLe, e.rdataLe); end
      end
    end
  endtask

  task automatic test_backpressure;
    exp_t e; int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    sb.push_back('{32'hDEAD1234, 32'h1234BEEF, 1'b0, 1'b0, 4'd2});
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h010; req_wdata = '0;
    @(negedge clk);
    req_we = 1'b1; req_funct3 = SW; req_addr = 32'h000; req_wdata = 32'hFFFFFFFF;
    lat = 1;
    while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; end
    e = sb.pop_front();
    assertCount++; if (rsp_rdata !== e.rdata) begin failCount++; $display("[TB] FAIL hold rdata: got %h, expected %h", rsp_rdata, e.rdata); end
    assertCount++; if (lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL hold latency: got %0d, expected %0d", lat, e.lat); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      assertCount++; if (rsp_valid !== 1'b1) begin failCount++; $display("[TB] FAIL hold[%0d] rsp_valid: got %b, expected 1", c, rsp_valid); end
      assertCount++; if (rsp_rdata !== e.rdata || rsp_err !== 1'b0) begin failCount++; $display("[TB] FAIL hold[%0d] rdata/err: got %h/%b, expected %h/0", c, rsp_rdata, rsp_err, e.rdata); end
      assertCount++; if (req_ready !== 1'b0) begin failCount++; $display("[TB] FAIL hold[%0d] req_ready: got %b, expected 0", c, req_ready); end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    assertCount++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL release valid/ready: got %b/%b, expected 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, rdLe; logic er; int lat; exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h010;
    @(negedge clk);
    req_valid = 1'b0;
    assertCount++; if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset READ rsp_valid: got %b, expected 0", rsp_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    assertCount++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin failCount++; $display("[TB] FAIL midreset flush: got %b/%h/%b, expected 0/00000000/0", rsp_valid, rsp_rdata, rsp_err); end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      assertCount++; if (req_ready !== 1'b1) begin failCount++; $display("[TB] FAIL midreset[%0d] req_ready: got %b, expected 1", c, req_ready); end
      assertCount++; if (rsp_valid !== 1'b0) begin failCount++; $display("[TB] FAIL midreset[%0d] stale rsp_valid: got %b, expected 0", c, rsp_valid); end
    end
    sb.push_back('{32'h11223344, 32'h11223344, 1'b1, 1'b0, 4'd2});
    sendReq(1'b0, LW, 32'h000, 32'h0, rd, rdLe, er, lat);
    e = sb.pop_front();
    assertCount++; if (rd !== e.rdata || rdLe !== e.rdataLe) begin failCount++; $display("[TB] FAIL after-reset rdata: got %h/%h, expected %h", rd, rdLe, e.rdata); end
    assertCount++; if (er !== e.err || lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL after-reset err/lat: got %b/%0d, expected 0/2", er, lat); end
  endtask

  // Random aligned traffic against a big-endian byte-array model of 0x020..0x03F.
  task automatic test_back_to_back;
    logic [31:0] rd, rdLe, wd, a, v; logic er; int lat; exp_t e;
    int sz, off; logic we, sgn; logic [2:0] f3;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      for (int k = 0; k < 4; k++) modelMem[4*w+k] = wd[8*(3-k) +: 8];
      sb.push_back('{32'h0, 32'h0, 1'b0, 1'b0, 4'd1});
      sendReq(1'b1, SW, 32'h020 + 32'(4*w), wd, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata || er !== e.err || lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL fill[%0d]: got %h/%b/%0d, expected %h/%b/%0d", w, rd, er, lat, e.rdata, e.err, e.lat); end
    end
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       sz = 1;
        1:       sz = 2;
        default: sz = 4;
      endcase
      off = int'($urandom_range(0, 31)) & ~(sz - 1);
      a = 32'h020 + 32'(off);
      f3 = (sz == 1) ? 3'b000 : (sz == 2) ? 3'b001 : 3'b010;
      if (!we && !sgn && sz != 4) f3[2] = 1'b1;
      if (we) begin
        wd = $urandom;
        for (int k = 0; k < sz; k++) modelMem[off+k] = wd[8*(sz-1-k) +: 8];
        sb.push_back('{32'h0, 32'h0, 1'b0, 1'b0, 4'd1});
      end else begin
        wd = '0;
        v = '0;
        for (int k = 0; k < sz; k++) v = (v << 8) | 32'(modelMem[off+k]);
        if (sgn && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (sgn && sz == 2) v = {{16{v[15]}}, v[15:0]};
        sb.push_back('{v, 32'h0, 1'b0, 1'b0, 4'd2});
      end
      sendReq(we, f3, a, wd, rd, rdLe, er, lat);
      e = sb.pop_front();
      assertCount++; if (rd !== e.rdata) begin failCount++; $display("[TB] FAIL rand[%0d] rdata: got %h, expected %h (we=%b f3=%b addr=%h)", i, rd, e.rdata, we, f3, a); end
      assertCount++; if (er !== e.err || lat != int'(e.lat)) begin failCount++; $display("[TB] FAIL rand[%0d] err/lat: got %b/%0d, expected %b/%0d", i, er, lat, e.err, e.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
